// File: rtl/psr_unit.sv
// Processor status register: masked ALU flag capture, LPR load, condition
// evaluation against the registered flags, and a small LIFO of saved PSRs
// used on interrupt entry and exit.
module psr_unit #(
    parameter int STACK_DEPTH = 4,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic          I_CLK,
    input  logic          I_NRESET,
    input  logic [3:0]    I_OPCODE,
    input  logic [4:0]    I_STATUS,
    input  logic          I_UPDATE_EN,
    input  logic          I_LOAD_EN,
    input  logic [4:0]    I_LOAD_DATA,
    input  logic          I_PUSH,
    input  logic          I_POP,
    input  logic          I_ERR_CLR,
    input  logic [3:0]    I_COND,
    output logic [4:0]    O_PSR,
    output logic          O_CARRY,
    output logic          O_COND_TRUE,
    output logic [DW-1:0] O_DEPTH,
    output logic          O_FULL,
    output logic          O_EMPTY,
    output logic          O_STACK_ERR
);
    // Stack index width; kept at least 1 bit so a single-entry stack still works.
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Flag bit positions within the PSR.
    localparam int C_BIT = 0;
    localparam int L_BIT = 1;
    localparam int F_BIT = 2;
    localparam int Z_BIT = 3;
    localparam int N_BIT = 4;

    logic [4:0]    psr_q, psr_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [4:0]    stack_mem [STACK_DEPTH];

    logic          full, empty;
    logic          push_only, pop_only;
    logic          push_ok, pop_ok, err_new;
    logic [AW-1:0] top_idx, wr_idx;
    logic [4:0]    upd_mask;
    logic          cond_true;

    assign full      = (depth_q == DW'(STACK_DEPTH));
    assign empty     = (depth_q == '0);
    // Push and pop together cancel out: stack untouched, never an error.
    assign push_only = I_PUSH && !I_POP;
    assign pop_only  = I_POP && !I_PUSH;
    assign push_ok   = push_only && !full;
    assign pop_ok    = pop_only && !empty;
    assign err_new   = (push_only && full) || (pop_only && empty);
    assign top_idx   = AW'(depth_q - DW'(1));
    assign wr_idx    = AW'(depth_q);

    // Which PSR bits each ALU opcode is allowed to modify.
    always_comb begin
        upd_mask = 5'b00000;
        case (I_OPCODE)
            4'd0, 4'd1: upd_mask = 5'b11101;              // ADD/ADDC: C,F,Z,N
            4'd3:       upd_mask = 5'b11111;              // SUB: all flags
            4'd2, 4'd4, 4'd5, 4'd6, 4'd7,
            4'd8, 4'd9, 4'd10, 4'd11: upd_mask = 5'b11000; // Z,N only
            default:    upd_mask = 5'b00000;
        endcase
    end

    // Next-state selection: valid pop beats LPR, which beats ALU update.
    always_comb begin
        psr_d   = psr_q;
        depth_d = depth_q;
        err_d   = err_q;
        if (pop_ok) begin
            psr_d = stack_mem[top_idx];
        end else if (I_LOAD_EN) begin
            psr_d = I_LOAD_DATA;
        end else if (I_UPDATE_EN) begin
            psr_d = (psr_q & ~upd_mask) | (I_STATUS & upd_mask);
        end
        if (push_ok) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_ok) begin
            depth_d = depth_q - DW'(1);
        end
        // A fresh error in the clearing cycle keeps the flag set.
        if (err_new) begin
            err_d = 1'b1;
        end else if (I_ERR_CLR) begin
            err_d = 1'b0;
        end
    end

    // PSR, occupancy and sticky error state.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            psr_q   <= 5'b00000;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            psr_q   <= psr_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Save storage: contents are irrelevant after reset, so no reset here.
    always_ff @(posedge I_CLK) begin
        if (push_ok) begin
            stack_mem[wr_idx] <= psr_q;
        end
    end

    // Condition codes evaluated against the registered flags only.
    always_comb begin
        cond_true = 1'b0;
        case (I_COND)
            4'd0:  cond_true =  psr_q[Z_BIT];
            4'd1:  cond_true = !psr_q[Z_BIT];
            4'd2:  cond_true =  psr_q[C_BIT];
            4'd3:  cond_true = !psr_q[C_BIT];
            4'd4:  cond_true =  psr_q[L_BIT];
            4'd5:  cond_true = !psr_q[L_BIT];
            4'd6:  cond_true =  psr_q[N_BIT];
            4'd7:  cond_true = !psr_q[N_BIT];
            4'd8:  cond_true =  psr_q[F_BIT];
            4'd9:  cond_true = !psr_q[F_BIT];
            4'd10: cond_true = !psr_q[L_BIT] && !psr_q[Z_BIT];
            4'd11: cond_true =  psr_q[L_BIT] ||  psr_q[Z_BIT];
            4'd12: cond_true = !psr_q[N_BIT] && !psr_q[Z_BIT];
            4'd13: cond_true =  psr_q[N_BIT] ||  psr_q[Z_BIT];
            4'd14: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign O_PSR       = psr_q;
    assign O_CARRY     = psr_q[C_BIT];
    assign O_COND_TRUE = cond_true;
    assign O_DEPTH     = depth_q;
    assign O_FULL      = full;
    assign O_EMPTY     = empty;
    assign O_STACK_ERR = err_q;

endmodule

// File: tb/tb_psr_unit.sv
// Directed table of single-cycle vectors for psr_unit, with hand-computed
// expected state after each clock edge, plus hand-written reset sequences.
module tb_psr_unit;
    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic [4:0] status;
    logic       upd, ld, push, pop, clr;
    logic [4:0] ldata;
    logic [3:0] cond;
    logic [4:0] psr;
    logic       carry, cond_true, full, empty, err;
    logic [2:0] depth;

    int total = 0;
    int bad   = 0;

    psr_unit #(.STACK_DEPTH(4)) dut (
        .I_CLK(clk), .I_NRESET(rst_n), .I_OPCODE(opcode), .I_STATUS(status),
        .I_UPDATE_EN(upd), .I_LOAD_EN(ld), .I_LOAD_DATA(ldata),
        .I_PUSH(push), .I_POP(pop), .I_ERR_CLR(clr), .I_COND(cond),
        .O_PSR(psr), .O_CARRY(carry), .O_COND_TRUE(cond_true), .O_DEPTH(depth),
        .O_FULL(full), .O_EMPTY(empty), .O_STACK_ERR(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [4:0] st;
        logic       upd;
        logic       ld;
        logic [4:0] ldd;
        logic       push;
        logic       pop;
        logic       clr;
        logic [3:0] cond;
        logic [4:0] e_psr;
        logic [2:0] e_depth;
        logic       e_err;
        logic       e_cond;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic [3:0] op, input logic [4:0] st, input logic u,
                               input logic l, input logic [4:0] ldd, input logic pu,
                               input logic po, input logic cl, input logic [3:0] c,
                               input logic [4:0] ep, input logic [2:0] ed,
                               input logic ee, input logic ec);
        vec_t r;
        r.op = op; r.st = st; r.upd = u; r.ld = l; r.ldd = ldd; r.push = pu;
        r.pop = po; r.clr = cl; r.cond = c; r.e_psr = ep; r.e_depth = ed;
        r.e_err = ee; r.e_cond = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        opcode = 4'd0; status = 5'd0; upd = 0; ld = 0; ldata = 5'd0;
        push = 0; pop = 0; clr = 0; cond = 4'd14;
    endtask

    initial begin
        // Stimulus table: op, status, upd, ld, ldata, push, pop, clr, cond | psr, depth, err, cond_true
        // Masking and flag/condition checks
        vq.push_back(v(0, 5'b00000, 0, 1, 5'b11111, 0, 0, 0, 14, 5'b11111, 0, 0, 1));
        vq.push_back(v(5, 5'b00000, 1, 0, 5'b00000, 0, 0, 0, 0,  5'b00111, 0, 0, 0));
        vq.push_back(v(14,5'b00000, 1, 0, 5'b00000, 0, 0, 0, 0,  5'b00111, 0, 0, 0));
        vq.push_back(v(3, 5'b10010, 1, 0, 5'b00000, 0, 0, 0, 6,  5'b10010, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 4,  5'b10010, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 7,  5'b10010, 0, 0, 0));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 13, 5'b10010, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 0,  5'b10010, 0, 0, 0));
        vq.push_back(v(3, 5'b01000, 1, 0, 5'b00000, 0, 0, 0, 0,  5'b01000, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 11, 5'b01000, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 10, 5'b01000, 0, 0, 0));
        vq.push_back(v(0, 5'b00000, 1, 1, 5'b10101, 0, 0, 0, 8,  5'b10101, 0, 0, 1));
        vq.push_back(v(0, 5'b11111, 1, 0, 5'b00000, 0, 0, 0, 4,  5'b11101, 0, 0, 0));
        vq.push_back(v(2, 5'b00000, 1, 0, 5'b00000, 0, 0, 0, 2,  5'b00101, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 3,  5'b00101, 0, 0, 0));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 5,  5'b00101, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 9,  5'b00101, 0, 0, 0));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 12, 5'b00101, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 15, 5'b00101, 0, 0, 0));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 1,  5'b00101, 0, 0, 1));
        vq.push_back(v(7, 5'b11111, 1, 0, 5'b00000, 0, 0, 0, 0,  5'b11101, 0, 0, 1));
        vq.push_back(v(1, 5'b00000, 1, 0, 5'b00000, 0, 0, 0, 2,  5'b00000, 0, 0, 0));
        // Stack fill, overflow, drain, underflow
        vq.push_back(v(0, 5'b00000, 0, 1, 5'b00001, 0, 0, 0, 2,  5'b00001, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 1, 5'b00010, 1, 0, 0, 14, 5'b00010, 1, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 1, 5'b00011, 1, 0, 0, 14, 5'b00011, 2, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 1, 5'b00100, 1, 0, 0, 14, 5'b00100, 3, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 1, 0, 0, 14, 5'b00100, 4, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 1, 5'b11111, 1, 0, 0, 14, 5'b11111, 4, 1, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 1, 0, 14, 5'b00100, 3, 1, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 1, 0, 14, 5'b00011, 2, 1, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 1, 0, 14, 5'b00010, 1, 1, 1));
        vq.push_back(v(0, 5'b00000, 1, 1, 5'b10101, 0, 1, 0, 14, 5'b00001, 0, 1, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 1, 0, 14, 5'b00001, 0, 1, 1));
        vq.push_back(v(0, 5'b00000, 0, 1, 5'b00110, 0, 1, 0, 14, 5'b00110, 0, 1, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 1, 14, 5'b00110, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 1, 1, 14, 5'b00110, 0, 1, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 0, 1, 14, 5'b00110, 0, 0, 1));
        // Simultaneous push+pop
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 1, 0, 0, 14, 5'b00110, 1, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 1, 5'b01001, 0, 0, 0, 14, 5'b01001, 1, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 1, 0, 0, 14, 5'b01001, 2, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 1, 1, 0, 14, 5'b01001, 2, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 1, 5'b00000, 1, 1, 0, 14, 5'b00000, 2, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 1, 0, 14, 5'b01001, 1, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 0, 1, 0, 14, 5'b00110, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 1, 1, 0, 14, 5'b00110, 0, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 1, 0, 0, 14, 5'b00110, 1, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 1, 0, 0, 14, 5'b00110, 2, 0, 1));
        vq.push_back(v(0, 5'b00000, 0, 0, 5'b00000, 1, 0, 0, 14, 5'b00110, 3, 0, 1));

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        #3;
        check("rst_psr", 8'(psr), 8'h00);
        check("rst_depth", 8'(depth), 8'h00);
        check("rst_empty", 8'(empty), 8'h01);
        check("rst_err", 8'(err), 8'h00);
        check("rst_uc", 8'(cond_true), 8'h01);
        cond = 4'd0;
        #1;
        check("rst_eq", 8'(cond_true), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            opcode = vq[i].op; status = vq[i].st; upd = vq[i].upd; ld = vq[i].ld;
            ldata = vq[i].ldd; push = vq[i].push; pop = vq[i].pop; clr = vq[i].clr;
            cond = vq[i].cond;
            @(posedge clk);
            #1;
            $display("vec %0d: psr=%b depth=%0d err=%b cond_true=%b", i, psr, depth, err, cond_true);
            check($sformatf("v%0d_psr", i), 8'(psr), 8'(vq[i].e_psr));
            check($sformatf("v%0d_carry", i), 8'(carry), 8'(vq[i].e_psr[0]));
            check($sformatf("v%0d_depth", i), 8'(depth), 8'(vq[i].e_depth));
            check($sformatf("v%0d_full", i), 8'(full), 8'(vq[i].e_depth == 3'd4));
            check($sformatf("v%0d_empty", i), 8'(empty), 8'(vq[i].e_depth == 3'd0));
            check($sformatf("v%0d_err", i), 8'(err), 8'(vq[i].e_err));
            check($sformatf("v%0d_cond", i), 8'(cond_true), 8'(vq[i].e_cond));
        end

        // Asynchronous reset at depth 3, between clock edges
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_depth", 8'(depth), 8'h00);
        check("mid_rst_empty", 8'(empty), 8'h01);
        check("mid_rst_psr", 8'(psr), 8'h00);
        @(posedge clk);
        #1;
        check("held_rst_depth", 8'(depth), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        // After reset, a pop finds an empty stack
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        check("post_rst_pop_err", 8'(err), 8'h01);
        check("post_rst_pop_psr", 8'(psr), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
